// File: rtl/image_feed.sv
// image_feed: pulls GROUP_NB-wide image words from upstream and feeds the layers block
// through an output register plus one skid entry. IMAGE_FEED_STATS_EN adds stall_cnt.
`timescale 1ns/1ps
module image_feed #(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned GROUP_NB   = 4,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  // Address of the feed config register (CFG_FEED in cfg_parameters.vh)
  parameter logic [CFG_AWIDTH-1:0] CFG_FEED = CFG_AWIDTH'(3)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy,
  output logic                          busy,
  output logic                          done
`ifdef IMAGE_FEED_STATS_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int unsigned DW = GROUP_NB * IMG_WIDTH;
  localparam int unsigned LW = 2 * CNT_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] bpp_q, bpp_d, pix_q, pix_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d, pixel_cnt_q, pixel_cnt_d;
  logic [LW-1:0]        in_left_q, in_left_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DW-1:0]        skid_data_q, skid_data_d;
  logic                 up_ready_q, up_ready_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic                 cfg_hit_c, accept_c, emit_c;
  logic [CNT_WIDTH-1:0] cfg_bpp_c, cfg_pix_c, bpp_m1_c, pix_m1_c;

  always_comb begin
    state_d      = state_q;
    bpp_d        = bpp_q;
    pix_d        = pix_q;
    beat_cnt_d   = beat_cnt_q;
    pixel_cnt_d  = pixel_cnt_q;
    in_left_d    = in_left_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    cfg_hit_c = cfg_valid && (cfg_addr == CFG_FEED);
    cfg_bpp_c = CNT_WIDTH'(cfg_data[15:0]);
    cfg_pix_c = CNT_WIDTH'(cfg_data[31:16]);
    if (cfg_bpp_c == '0) cfg_bpp_c = CNT_WIDTH'(1);
    accept_c  = up_valid && up_ready_q;
    emit_c    = out_valid_q && image_rdy;
    bpp_m1_c  = bpp_q - CNT_WIDTH'(1);
    pix_m1_c  = pix_q - CNT_WIDTH'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_hit_c) begin
          bpp_d = cfg_bpp_c;
          pix_d = cfg_pix_c;
          if (cfg_pix_c != '0) begin
            state_d     = ST_STREAM;
            in_left_d   = LW'(cfg_bpp_c) * LW'(cfg_pix_c);
            beat_cnt_d  = '0;
            pixel_cnt_d = '0;
          end
        end
      end
      ST_STREAM: begin
        if (accept_c) in_left_d = in_left_q - LW'(1);
        if (emit_c) begin
          if (beat_cnt_q == bpp_m1_c) begin
            beat_cnt_d  = '0;
            pixel_cnt_d = pixel_cnt_q + CNT_WIDTH'(1);
            if (pixel_cnt_q == pix_m1_c) state_d = ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
        // Output register refills from the skid first so ordering stays FIFO
        if (!out_valid_q || emit_c) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = accept_c;
            if (accept_c) skid_data_d = up_data;
          end else begin
            out_valid_d = accept_c;
            out_data_d  = up_data;
          end
          // beat_cnt_d is the beat index of the word now entering the output register
          out_last_d = (beat_cnt_d == bpp_m1_c);
        end else if (accept_c) begin
          skid_valid_d = 1'b1;
          skid_data_d  = up_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    up_ready_d = (state_d == ST_STREAM) && !skid_valid_d && (in_left_d != '0);
    busy_d     = (state_d == ST_STREAM);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bpp_q        <= CNT_WIDTH'(1);
      pix_q        <= '0;
      beat_cnt_q   <= '0;
      pixel_cnt_q  <= '0;
      in_left_q    <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      up_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bpp_q        <= bpp_d;
      pix_q        <= pix_d;
      beat_cnt_q   <= beat_cnt_d;
      pixel_cnt_q  <= pixel_cnt_d;
      in_left_q    <= in_left_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      up_ready_q   <= up_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign image_bus  = out_data_q;
  assign image_last = out_last_q;
  assign image_val  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef IMAGE_FEED_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of stalled output cycles, cleared on each run start
  always_comb begin
    stall_d = stall_q;
    if (state_q != ST_STREAM && state_d == ST_STREAM) begin
      stall_d = '0;
    end else if (state_q == ST_STREAM && out_valid_q && !image_rdy && stall_q != '1) begin
      stall_d = stall_q + 32'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  // No stall statistics in this build
`endif

endmodule

// File: tb/tb_image_feed.sv
// tb_image_feed: randomized bench for image_feed against a queue-based reference model.
`timescale 1ns/1ps
module tb_image_feed;

  localparam logic [4:0] CFG_FEED = 5'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic [63:0] up_data;
  logic        up_valid;
  logic        up_ready;
  logic [63:0] image_bus;
  logic        image_last;
  logic        image_val;
  logic        image_rdy;
  logic        busy;
  logic        done;
`ifdef IMAGE_FEED_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_stall;

  always #5 clk = ~clk;

  image_feed #(.CFG_FEED(CFG_FEED)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy), .busy(busy), .done(done)
`ifdef IMAGE_FEED_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cfg_write(input int bpp, input int pix);
    cfg_valid = 1'b1;
    cfg_addr  = CFG_FEED;
    cfg_data  = {16'(pix), 16'(bpp)};
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // mode 0: rdy always high; 1: rdy low 12 cycles after each last; 2: random rdy low low_pct%
  task automatic run_feed(input int bpp, input int pix, input int mode, input int low_pct,
                          input int up_pct, input int abort_at, input bit poke);
    logic [63:0] q[$];
    logic [63:0] exp_word, prev_bus;
    logic        prev_last;
    bit          prev_stall;
    int eff, total, acc, emi, cyc, hold;
    eff = (bpp == 0) ? 1 : bpp;
    total = eff * pix;
    acc = 0; emi = 0; cyc = 0; hold = 0;
    prev_stall = 1'b0; prev_bus = '0; prev_last = 1'b0;
    exp_stall = 0;
    cfg_write(bpp, pix);
    check("busy_start", 64'(busy), 64'd1);
    while (emi < total && cyc < 4000) begin
      if (abort_at > 0 && emi == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_val", 64'(image_val), 64'd0);
        check("abort_up_ready", 64'(up_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        up_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 64'(done), 64'd0);
        end
        return;
      end
      check("done_early", 64'(done), 64'd0);
      check("buffered_le2", 64'(acc - emi <= 2), 64'd1);
      if (prev_stall) begin
        check("stall_bus_stable", image_bus, prev_bus);
        check("stall_last_stable", 64'(image_last), 64'(prev_last));
      end
      if (mode == 0 && up_pct == 100 && emi > 0)
        check("back_to_back", 64'(image_val), 64'd1);
      // Drive the inputs that the next rising edge will sample
      up_valid = ($urandom_range(99) < up_pct);
      up_data  = {$urandom, $urandom};
      case (mode)
        0:       image_rdy = 1'b1;
        1:       begin image_rdy = (hold == 0); if (hold > 0) hold--; end
        default: image_rdy = ($urandom_range(99) >= low_pct);
      endcase
      if (poke && cyc == 3) begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_FEED;
        cfg_data  = $urandom;
      end else begin
        cfg_valid = 1'b0;
      end
      if (busy && image_val && !image_rdy) exp_stall++;
      if (image_val && image_rdy) begin
        if (q.size() == 0) begin
          check("emit_without_source", 64'd1, 64'd0);
        end else begin
          exp_word = q.pop_front();
          check("order_data", image_bus, exp_word);
          check("image_last", 64'(image_last), 64'((emi % eff) == eff - 1));
          if (mode == 1 && (emi % eff) == eff - 1) hold = 12;
        end
        emi++;
      end
      if (up_valid && up_ready) begin
        check("no_overpull", 64'(acc < total), 64'd1);
        q.push_back(up_data);
        acc++;
      end
      prev_stall = image_val && !image_rdy;
      prev_bus   = image_bus;
      prev_last  = image_last;
      @(negedge clk);
      cyc++;
    end
    cfg_valid = 1'b0;
    up_valid  = 1'b0;
    check("run_complete", 64'(emi), 64'(total));
    check("done_pulse", 64'(done), 64'd1);
    check("busy_end", 64'(busy), 64'd0);
    check("val_end", 64'(image_val), 64'd0);
    check("up_ready_end", 64'(up_ready), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    up_valid = 1'b0; up_data = '0; image_rdy = 1'b0;
    #1;
    check("rst_val", 64'(image_val), 64'd0);
    check("rst_last", 64'(image_last), 64'd0);
    check("rst_up_ready", 64'(up_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_feed(9, 2, 0, 0, 100, 0, 1'b0);
    run_feed(9, 2, 1, 0, 100, 0, 1'b0);
    run_feed(0, 3, 0, 0, 100, 0, 1'b0);

    // pixel_nb of zero must leave the block idle
    cfg_write(5, 0);
    up_valid = 1'b1;
    image_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("pix0_busy", 64'(busy), 64'd0);
      check("pix0_up_ready", 64'(up_ready), 64'd0);
      check("pix0_val", 64'(image_val), 64'd0);
    end
    up_valid = 1'b0;

    run_feed(9, 2, 0, 0, 100, 4, 1'b0);
    run_feed(5, 2, 2, 30, 80, 0, 1'b0);

    run_feed(4, 16, 2, 30, 100, 0, 1'b0);
`ifdef IMAGE_FEED_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    repeat (3) @(negedge clk);
    check("stall_cnt_hold", 64'(stall_cnt), 64'(exp_stall));
`endif

    for (int r = 0; r < 4; r++)
      run_feed(int'($urandom_range(7, 1)), int'($urandom_range(4, 1)), 2, 30, 70, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
